// File: rtl/inst_fetch_ctrl_if.sv
// inst_fetch_ctrl_if: SRAM-like instruction read port between fetch controller and AXI bridge.
interface inst_fetch_ctrl_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );
  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: single-outstanding instruction fetch with decode buffer and redirect/discard handling.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  input  logic                      ds_allowin,
  output logic                      fs_to_ds_valid,
  output logic [31:0]               fs_pc,
  output logic [31:0]               fs_inst,
  inst_fetch_ctrl_if.master         sram
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, pend_pc_q, pend_pc_d, inst_q, inst_d;
  logic        pend_valid_q, pend_valid_d, discard_q, discard_d;
  logic [31:0] rpc;
  assign rpc = redirect_pc & ~32'h3;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    discard_d    = discard_q;
    inst_d       = inst_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pend_pc_d    = rpc;
          pend_valid_d = 1'b1;
          discard_d    = 1'b1;
        end
        if (sram.inst_sram_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sram.inst_sram_data_ok) begin
          // a redirect landing with the data beats any older pending target
          if (redirect_valid || discard_q) begin
            pc_d         = redirect_valid ? rpc : (pend_valid_q ? pend_pc_q : pc_q);
            discard_d    = 1'b0;
            pend_valid_d = 1'b0;
            state_d      = S_REQ;
          end else begin
            inst_d  = sram.inst_sram_rdata;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          discard_d    = 1'b1;
          pend_pc_d    = rpc;
          pend_valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid || ds_allowin) begin
          pc_d    = redirect_valid ? rpc : pc_q + PC_STEP;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      pend_valid_q <= 1'b0;
      discard_q    <= 1'b0;
      inst_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      discard_q    <= discard_d;
      inst_q       <= inst_d;
    end
  end
  assign fs_to_ds_valid       = state_q == S_HOLD;
  assign fs_pc                = pc_q;
  assign fs_inst              = inst_q;
  assign sram.inst_sram_req   = aresetn && state_q == S_REQ;
  assign sram.inst_sram_wr    = 1'b0;
  assign sram.inst_sram_size  = 2'b10;
  assign sram.inst_sram_wstrb = 4'b0;
  assign sram.inst_sram_addr  = pc_q;
  assign sram.inst_sram_wdata = '0;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed vector table, hand sequences and randomized run against a fetch-stream model.
module tb_inst_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h1c000000;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic rv = 1'b0, al = 1'b0;
  logic [31:0] rpc = '0;
  logic fs_to_ds_valid;
  logic [31:0] fs_pc, fs_inst;
  int checks = 0, failures = 0;
  inst_fetch_ctrl_if sram();
  inst_fetch_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .redirect_valid(rv), .redirect_pc(rpc), .ds_allowin(al),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst), .sram(sram.master)
  );
  always #5 aclk = ~aclk;
  typedef struct {
    logic rv; logic [31:0] rpc; logic al; logic aok; logic dok; logic [31:0] rdata;
    logic e_req; logic [31:0] e_addr; logic e_v; logic [31:0] e_pc; logic [31:0] e_inst;
  } vec_t;
  vec_t tv[$];
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [31:0] p, input logic a, input logic aok, input logic dok, input logic [31:0] d);
    rv = r; rpc = p; al = a;
    sram.inst_sram_addr_ok = aok; sram.inst_sram_data_ok = dok; sram.inst_sram_rdata = d;
    @(negedge aclk);
  endtask
  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask
  task automatic add(input logic r, input logic [31:0] p, input logic a, input logic aok, input logic dok, input logic [31:0] d,
                     input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    tv.push_back('{r, p, a, aok, dok, d, er, ea, ev, ep, ei});
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 32'(sram.inst_sram_req), 0);
    chk({tag, "_addr"}, sram.inst_sram_addr, RST_PC);
    chk({tag, "_fspc"}, fs_pc, RST_PC);
    chk({tag, "_valid"}, 32'(fs_to_ds_valid), 0);
    chk({tag, "_inst"}, fs_inst, 0);
  endtask
  logic [31:0] q[$];
  logic [31:0] exp_pc, prev_addr;
  logic prev_pend, aok, dok;
  int hand;
  initial begin
    sram.inst_sram_addr_ok = 1'b0; sram.inst_sram_data_ok = 1'b0; sram.inst_sram_rdata = '0;
    //  rv rpc            al aok dok rdata          req addr           v  pc             inst
    add(0, 0,             0, 0, 0, 0,             1, 32'h1c000000, 0, 0, 0);
    add(0, 0,             0, 1, 0, 0,             1, 32'h1c000000, 0, 0, 0);
    add(0, 0,             0, 0, 0, 0,             0, 0,            0, 0, 0);
    add(0, 0,             0, 0, 1, 32'h02800c0c,  0, 0,            0, 0, 0);
    add(0, 0,             1, 0, 0, 0,             0, 0,            1, 32'h1c000000, 32'h02800c0c);
    add(0, 0,             0, 1, 0, 0,             1, 32'h1c000004, 0, 0, 0);
    add(0, 0,             0, 0, 1, 32'h11111111,  0, 0,            0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0,           0, 0, 0, 0,             0, 0,            1, 32'h1c000004, 32'h11111111);
    add(0, 0,             1, 0, 0, 0,             0, 0,            1, 32'h1c000004, 32'h11111111);
    add(1, 32'h1c000100,  0, 0, 0, 0,             1, 32'h1c000008, 0, 0, 0);
    add(0, 0,             0, 0, 0, 0,             1, 32'h1c000008, 0, 0, 0);
    add(0, 0,             0, 0, 0, 0,             1, 32'h1c000008, 0, 0, 0);
    add(0, 0,             0, 1, 0, 0,             1, 32'h1c000008, 0, 0, 0);
    add(0, 0,             0, 0, 1, 32'hdeadbeef,  0, 0,            0, 0, 0);
    add(0, 0,             0, 1, 0, 0,             1, 32'h1c000100, 0, 0, 0);
    add(1, 32'h1c000200,  0, 0, 1, 32'h22222222,  0, 0,            0, 0, 0);
    add(0, 0,             0, 1, 0, 0,             1, 32'h1c000200, 0, 0, 0);
    add(1, 32'h1c000300,  0, 0, 0, 0,             0, 0,            0, 0, 0);
    add(1, 32'h1c000400,  0, 0, 0, 0,             0, 0,            0, 0, 0);
    add(0, 0,             0, 0, 1, 32'h33333333,  0, 0,            0, 0, 0);
    add(0, 0,             0, 1, 0, 0,             1, 32'h1c000400, 0, 0, 0);
    add(0, 0,             0, 0, 1, 32'h44444444,  0, 0,            0, 0, 0);
    add(1, 32'h1c000503,  1, 0, 0, 0,             0, 0,            1, 32'h1c000400, 32'h44444444);
    add(0, 0,             0, 0, 0, 0,             1, 32'h1c000500, 0, 0, 0);
    repeat (2) @(negedge aclk);
    chk_reset("in_reset");
    chk("const_wr", 32'(sram.inst_sram_wr), 0);
    chk("const_size", 32'(sram.inst_sram_size), 2);
    chk("const_wstrb", 32'(sram.inst_sram_wstrb), 0);
    chk("const_wdata", sram.inst_sram_wdata, 0);
    nxt();
    aresetn = 1'b1;
    foreach (tv[i]) begin
      drive(tv[i].rv, tv[i].rpc, tv[i].al, tv[i].aok, tv[i].dok, tv[i].rdata);
      chk($sformatf("vec%0d_req", i), 32'(sram.inst_sram_req), 32'(tv[i].e_req));
      chk($sformatf("vec%0d_valid", i), 32'(fs_to_ds_valid), 32'(tv[i].e_v));
      if (tv[i].e_req) chk($sformatf("vec%0d_addr", i), sram.inst_sram_addr, tv[i].e_addr);
      if (tv[i].e_v) begin
        chk($sformatf("vec%0d_pc", i), fs_pc, tv[i].e_pc);
        chk($sformatf("vec%0d_inst", i), fs_inst, tv[i].e_inst);
      end
      nxt();
    end
    // redirect coinciding with addr_ok, then wrap of the PC past 2^32
    drive(1, 32'hfffffffc, 0, 1, 0, 0);
    chk("wrap_req_old", sram.inst_sram_addr, 32'h1c000500);
    nxt();
    drive(0, 0, 0, 0, 1, 32'h66666666);
    chk("wrap_wait_req", 32'(sram.inst_sram_req), 0);
    nxt();
    drive(0, 0, 0, 1, 0, 0);
    chk("wrap_dropped", 32'(fs_to_ds_valid), 0);
    chk("wrap_redir_addr", sram.inst_sram_addr, 32'hfffffffc);
    nxt();
    drive(0, 0, 0, 0, 1, 32'h77777777);
    nxt();
    drive(0, 0, 1, 0, 0, 0);
    chk("wrap_pc", fs_pc, 32'hfffffffc);
    chk("wrap_inst", fs_inst, 32'h77777777);
    nxt();
    drive(0, 0, 0, 1, 0, 0);
    chk("wrap_next_req", 32'(sram.inst_sram_req), 1);
    chk("wrap_next_addr", sram.inst_sram_addr, 32'h00000000);
    nxt();
    drive(0, 0, 0, 0, 0, 0);
    #1 aresetn = 1'b0;
    #1 chk_reset("mid_reset");
    nxt();
    aresetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    chk("restart_req", 32'(sram.inst_sram_req), 1);
    chk("restart_addr", sram.inst_sram_addr, RST_PC);
    nxt();
    // randomized run: decode must see the sequential stream, restarted at each redirect target
    exp_pc = RST_PC; prev_pend = 1'b0; prev_addr = '0; hand = 0;
    for (int n = 0; n < 3000; n++) begin
      aok = sram.inst_sram_req && $urandom_range(0, 1) == 1;
      dok = q.size() != 0 && $urandom_range(0, 2) == 0;
      drive($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 1) == 1, aok, dok, dok ? mem(q[0]) : $urandom);
      if (prev_pend) begin
        chk("rnd_req_held", 32'(sram.inst_sram_req), 1);
        chk("rnd_addr_held", sram.inst_sram_addr, prev_addr);
      end
      if (sram.inst_sram_req) chk("rnd_single_outstanding", q.size(), 0);
      if (fs_to_ds_valid && al && !rv) begin
        chk("rnd_pc", fs_pc, exp_pc);
        chk("rnd_inst", fs_inst, mem(exp_pc));
        exp_pc += 32'd4;
        hand++;
      end
      if (rv) exp_pc = rpc & ~32'h3;
      prev_pend = sram.inst_sram_req && !aok;
      prev_addr = sram.inst_sram_addr;
      if (sram.inst_sram_req && aok) q.push_back(sram.inst_sram_addr);
      if (dok) void'(q.pop_front());
      nxt();
    end
    chk("rnd_progress", 32'(hand > 20), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
